// File: rtl/ir_tx_scheduler.sv
// Round-robin arbiter in front of a single NEC-style IR frame sequencer.
// Produces a registered mark/space envelope and its 36 kHz carrier-modulated drive.
module ir_tx_scheduler #(
  parameter int CARRIER_HALF = 694,
  parameter int UNIT_CYCLES  = 28125,
  parameter int GAP_UNITS    = 72
) (
  input  logic        In_Clock,
  input  logic        In_Reset_N,
  input  logic        In_Req_A,
  input  logic [15:0] In_Cmd_A,
  output logic        Out_Ack_A,
  input  logic        In_Req_B,
  input  logic [15:0] In_Cmd_B,
  output logic        Out_Ack_B,
  output logic        Out_Busy,
  output logic        Out_Envelope,
  output logic        Out_IR,
  output logic        Out_Done,
  output logic        Out_Grant
);

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_LEAD_MARK  = 3'd1;
  localparam logic [2:0] ST_LEAD_SPACE = 3'd2;
  localparam logic [2:0] ST_BIT_MARK   = 3'd3;
  localparam logic [2:0] ST_BIT_SPACE  = 3'd4;
  localparam logic [2:0] ST_STOP_MARK  = 3'd5;
  localparam logic [2:0] ST_GAP        = 3'd6;

  localparam int MAX_UNITS = (GAP_UNITS > 16) ? GAP_UNITS : 16;
  localparam int CYC_W     = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam int UNIT_W    = $clog2(MAX_UNITS);
  localparam int CAR_W     = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;

  localparam logic [CYC_W-1:0]  CYC_LAST = CYC_W'(UNIT_CYCLES - 1);
  localparam logic [CAR_W-1:0]  CAR_LAST = CAR_W'(CARRIER_HALF - 1);
  localparam logic [UNIT_W-1:0] GAP_LAST = UNIT_W'(GAP_UNITS - 1);

  logic [2:0]        r_state;
  logic [CYC_W-1:0]  r_cycleCnt;
  logic [UNIT_W-1:0] r_unitCnt;
  logic [4:0]        r_bitIdx;
  logic [31:0]       r_shift;
  logic              r_pointer;
  logic [CAR_W-1:0]  r_carCnt;
  logic              r_phase;
  logic              r_ackA;
  logic              r_ackB;
  logic              r_busy;
  logic              r_env;
  logic              r_ir;
  logic              r_done;
  logic              r_grant;

  logic [2:0]        w_nextState;
  logic [UNIT_W-1:0] w_lastUnit;
  logic              w_unitDone;
  logic              w_grantA;
  logic              w_grantB;
  logic              w_win;
  logic [15:0]       w_cmd;
  logic [31:0]       w_payload;
  logic              w_nextMark;
  logic              w_markEntry;
  logic [CAR_W-1:0]  w_nextCarCnt;
  logic              w_nextPhase;

  // r_pointer = 1 means B is favoured on the next contended arbitration
  assign w_grantA  = In_Req_A && (!In_Req_B || !r_pointer);
  assign w_grantB  = In_Req_B && !w_grantA;
  assign w_win     = (r_state == ST_IDLE) && (w_grantA || w_grantB);
  assign w_cmd     = w_grantA ? In_Cmd_A : In_Cmd_B;
  assign w_payload = {~w_cmd[7:0], w_cmd[7:0], ~w_cmd[15:8], w_cmd[15:8]};

  always_comb begin
    w_lastUnit = '0;
    case (r_state)
      ST_LEAD_MARK:  w_lastUnit = UNIT_W'(15);
      ST_LEAD_SPACE: w_lastUnit = UNIT_W'(7);
      ST_BIT_SPACE:  w_lastUnit = r_shift[0] ? UNIT_W'(2) : UNIT_W'(0);
      ST_GAP:        w_lastUnit = GAP_LAST;
      default:       w_lastUnit = '0;
    endcase
  end

  assign w_unitDone = (r_cycleCnt == CYC_LAST) && (r_unitCnt == w_lastUnit);

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:       if (w_win)      w_nextState = ST_LEAD_MARK;
      ST_LEAD_MARK:  if (w_unitDone) w_nextState = ST_LEAD_SPACE;
      ST_LEAD_SPACE: if (w_unitDone) w_nextState = ST_BIT_MARK;
      ST_BIT_MARK:   if (w_unitDone) w_nextState = ST_BIT_SPACE;
      ST_BIT_SPACE:  if (w_unitDone) w_nextState = (r_bitIdx == 5'd31) ? ST_STOP_MARK : ST_BIT_MARK;
      ST_STOP_MARK:  if (w_unitDone) w_nextState = ST_GAP;
      ST_GAP:        if (w_unitDone) w_nextState = ST_IDLE;
      default:       w_nextState = ST_IDLE;
    endcase
  end

  assign w_nextMark  = (w_nextState == ST_LEAD_MARK) || (w_nextState == ST_BIT_MARK) ||
                       (w_nextState == ST_STOP_MARK);
  assign w_markEntry = w_nextMark && (w_nextState != r_state);

  // Carrier restarts high on each mark entry and is parked low outside marks
  always_comb begin
    w_nextCarCnt = '0;
    w_nextPhase  = 1'b0;
    if (w_markEntry) begin
      w_nextPhase = 1'b1;
    end else if (w_nextMark) begin
      if (r_carCnt == CAR_LAST) begin
        w_nextPhase = ~r_phase;
      end else begin
        w_nextCarCnt = r_carCnt + 1'b1;
        w_nextPhase  = r_phase;
      end
    end
  end

  always_ff @(posedge In_Clock or negedge In_Reset_N) begin
    if (!In_Reset_N) begin
      r_state    <= ST_IDLE;
      r_cycleCnt <= '0;
      r_unitCnt  <= '0;
      r_bitIdx   <= '0;
      r_shift    <= '0;
      r_pointer  <= 1'b0;
      r_carCnt   <= '0;
      r_phase    <= 1'b0;
      r_ackA     <= 1'b0;
      r_ackB     <= 1'b0;
      r_busy     <= 1'b0;
      r_env      <= 1'b0;
      r_ir       <= 1'b0;
      r_done     <= 1'b0;
      r_grant    <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if ((w_nextState != r_state) || (r_state == ST_IDLE)) begin
        r_cycleCnt <= '0;
        r_unitCnt  <= '0;
      end else if (r_cycleCnt == CYC_LAST) begin
        r_cycleCnt <= '0;
        r_unitCnt  <= r_unitCnt + 1'b1;
      end else begin
        r_cycleCnt <= r_cycleCnt + 1'b1;
      end

      if (w_win) begin
        r_shift   <= w_payload;
        r_bitIdx  <= '0;
        r_pointer <= w_grantA;
        r_grant   <= w_grantB;
      end else if ((r_state == ST_BIT_SPACE) && w_unitDone && (r_bitIdx != 5'd31)) begin
        r_shift  <= {1'b0, r_shift[31:1]};
        r_bitIdx <= r_bitIdx + 5'd1;
      end

      r_carCnt <= w_nextCarCnt;
      r_phase  <= w_nextPhase;
      r_ackA   <= w_win && w_grantA;
      r_ackB   <= w_win && w_grantB;
      r_busy   <= (w_nextState != ST_IDLE);
      r_env    <= w_nextMark;
      r_ir     <= w_nextMark && w_nextPhase;
      r_done   <= (r_state == ST_STOP_MARK) && (w_nextState == ST_GAP);
    end
  end

  assign Out_Ack_A    = r_ackA;
  assign Out_Ack_B    = r_ackB;
  assign Out_Busy     = r_busy;
  assign Out_Envelope = r_env;
  assign Out_IR       = r_ir;
  assign Out_Done     = r_done;
  assign Out_Grant    = r_grant;

endmodule
